fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/cavlc_fifo_pkg.sv | 20 ++
 rtl/fifo_rd_outreg.sv | 57 +++++
 rtl/fifo_read_ctrl.sv | 73 +++++++
 tb/tb_fifo_read_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cavlc_fifo_pkg.sv
// Shared FIFO definitions for the reader- and writer-side controllers.
// Default geometry is 16-bit words, depth 8, one wrap bit on each pointer.
package cavlc_fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_PTR_W  = DEF_ADDR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Occupancy from two wrap-bit pointers; modulo arithmetic handles the wrap.
    function automatic logic [DEF_PTR_W-1:0] ptrDiff(input logic [DEF_PTR_W-1:0] wr,
                                                     input logic [DEF_PTR_W-1:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// Output holding register for the FIFO reader: IDLE/STREAM valid-ready handshake.
// Loads a new word on every pop, including back-to-back with an accept.
module fifo_rd_outreg
    import cavlc_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Flush,
    input  logic              Pop,
    input  logic              OutReady,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid
);

    rd_state_e state, stateNext;
    logic      loadData;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadData  = 1'b0;
        case (state)
            IDLE: begin
                if (Pop) begin
                    stateNext = STREAM;
                    loadData  = 1'b1;
                end
            end
            STREAM: begin
                // Pop in STREAM implies the current word is being accepted.
                if (Pop)           loadData  = 1'b1;
                else if (OutReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (Flush) begin
            stateNext = IDLE;
            loadData  = 1'b0;
        end
    end

    // Flush drops OutValid but leaves the stale word in place.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)       OutData <= '0;
        else if (loadData) OutData <= MemData;
    end

    assign OutValid = (state == STREAM);

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: read pointer, empty/overrun detection, output register.
// Define FIFO_RD_LEVEL_EN to expose the Level and AlmostEmpty ports.
module fifo_read_ctrl
    import cavlc_fifo_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int PTR_W  = ADDR_W + 1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [PTR_W-1:0]  WrPtr,
    input  logic [DATA_W-1:0] MemData,
    output logic [ADDR_W-1:0] AddrRead,
    output logic              OE,
    output logic [PTR_W-1:0]  RdPtr,
    input  logic              Flush,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Empty,
    output logic              Overrun
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [PTR_W-1:0]  Level,
    output logic              AlmostEmpty
`endif
);

    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1) << ADDR_W;

    logic             pop;
    logic [PTR_W-1:0] fillLevel;

    assign fillLevel = WrPtr - RdPtr;
    assign Empty     = (RdPtr == WrPtr);
    assign pop       = !Empty && !Flush && (!OutValid || OutReady);
    assign OE        = pop;
    assign AddrRead  = RdPtr[ADDR_W-1:0];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)    RdPtr <= '0;
        else if (Flush) RdPtr <= WrPtr;
        else if (pop)   RdPtr <= RdPtr + PTR_W'(1);
    end

    // More than DEPTH words outstanding means the writer lapped us.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)                Overrun <= 1'b0;
        else if (fillLevel > DEPTH) Overrun <= 1'b1;
    end

`ifdef FIFO_RD_LEVEL_EN
    assign Level       = fillLevel;
    assign AlmostEmpty = (fillLevel <= PTR_W'(1));
`else
    // Without the level ports, occupancy feeds only the overrun detector.
`endif

    fifo_rd_outreg #(
        .DATA_W (DATA_W)
    ) uOutReg (
        .Clk      (Clk),
        .nReset   (nReset),
        .Flush    (Flush),
        .Pop      (pop),
        .OutReady (OutReady),
        .MemData  (MemData),
        .OutData  (OutData),
        .OutValid (OutValid)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed scenarios plus random traffic against a queue model.
// Build with FIFO_RD_LEVEL_EN to also check Level/AlmostEmpty.
module tb_fifo_read_ctrl;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [3:0]  WrPtr;
    logic [15:0] MemData;
    logic [2:0]  AddrRead;
    logic        OE;
    logic [3:0]  RdPtr;
    logic        Flush;
    logic [15:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic        Empty;
    logic        Overrun;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0]  Level;
    logic        AlmostEmpty;
`endif

    always #5 Clk = ~Clk;

    logic [15:0] mem [8];
    assign MemData = mem[AddrRead];

    fifo_read_ctrl dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .WrPtr    (WrPtr),
        .MemData  (MemData),
        .AddrRead (AddrRead),
        .OE       (OE),
        .RdPtr    (RdPtr),
        .Flush    (Flush),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Empty    (Empty),
        .Overrun  (Overrun)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .Level       (Level),
        .AlmostEmpty (AlmostEmpty)
`endif
    );

    // Reference model: queue of words written but not yet popped.
    logic [15:0] q[$];
    logic [3:0]  mWr, mRd;
    logic        mValid, mOvr;
    logic [15:0] mData;
    int          nCmp = 0;
    int          nErr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mWr = '0; mRd = '0; mValid = 1'b0; mOvr = 1'b0; mData = '0;
        WrPtr = '0;
    endtask

    task automatic doReset();
        nReset = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_rdptr", RdPtr, 0);
        chk("rst_valid", OutValid, 0);
        chk("rst_data", OutData, 0);
        chk("rst_ovr", Overrun, 0);
        chk("rst_oe", OE, 0);
        nReset = 1'b1;
    endtask

    task automatic push(input logic [15:0] d);
        mem[mWr[2:0]] = d;
        q.push_back(d);
        mWr = mWr + 4'd1;
        WrPtr = mWr;
    endtask

    // One clock: check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic cycle(input logic fl, input logic rdy);
        logic       popExp;
        logic [3:0] lvl;
        Flush = fl; OutReady = rdy;
        #1;
        lvl    = mWr - mRd;
        popExp = (q.size() > 0) && !fl && (!mValid || rdy);
        chk("oe", OE, popExp);
        chk("empty", Empty, q.size() == 0);
        chk("addr", AddrRead, mRd[2:0]);
`ifdef FIFO_RD_LEVEL_EN
        chk("level", Level, lvl);
        chk("almost_empty", AlmostEmpty, lvl <= 4'd1);
`endif
        @(posedge Clk);
        #1;
        if (lvl > 4'd8) mOvr = 1'b1;
        if (fl) begin
            q.delete(); mRd = mWr; mValid = 1'b0;
        end else if (popExp) begin
            mData = q.pop_front(); mRd = mRd + 4'd1; mValid = 1'b1;
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        chk("valid", OutValid, mValid);
        if (mValid) chk("data", OutData, mData);
        chk("rdptr", RdPtr, mRd);
        chk("overrun", Overrun, mOvr);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // First word: OE same cycle, valid at the following edge.
        doReset();
        push(16'hA5A5);
        cycle(1'b0, 1'b1);
        chk("first_data", OutData, 16'hA5A5);
        chk("first_rdptr", RdPtr, 1);

        // Eight words stream out back-to-back.
        doReset();
        for (int i = 1; i <= 8; i++) push(16'(i));
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
        chk("fill_empty", Empty, 1);
        chk("fill_rdptr", RdPtr, 8);
        chk("fill_idle", OutValid, 0);

        // Stall for five cycles, then release.
        doReset();
        for (int i = 0; i < 4; i++) push(16'h1100 + 16'(i));
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);

        // Pointer wrap 14 -> 15 -> 0 -> 1 -> 2.
        doReset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 7; i++) push(16'h2000 + 16'(b * 7 + i));
            for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        end
        chk("wrap_start", RdPtr, 14);
        for (int i = 0; i < 4; i++) push(16'h3000 + 16'(i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        chk("wrap_end", RdPtr, 2);

        // Flush with words pending, then a writer jump that overruns.
        doReset();
        for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i));
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("flush_empty", Empty, 1);
        chk("flush_valid", OutValid, 0);
        for (int i = 0; i < 9; i++) push(16'h5000 + 16'(i));
        cycle(1'b1, 1'b0);
        chk("ovr_set", Overrun, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

        // Asynchronous reset discards the held word without a clock.
        doReset();
        push(16'h6666);
        cycle(1'b0, 1'b0);
        nReset = 1'b0;
        #1;
        chk("async_valid", OutValid, 0);
        chk("async_data", OutData, 0);
        chk("async_rdptr", RdPtr, 0);

        // Random traffic.
        doReset();
        for (int c = 0; c < 400; c++) begin
            int room, n;
            room = 8 - q.size();
            n = $urandom_range(0, (room < 2) ? room : 2);
            for (int k = 0; k < n; k++) push(16'($urandom));
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
